id_operand_stage: RTL and testbench

Parametrised decode/operand-fetch pipeline stage with a valid/ready handshake on both sides. It holds one instruction in a main register and one in a skid register, drives register-file read indices, and resolves each source operand against a configurable number of priority-ordered forwarding sources. A match that cannot be forwarded yet (load-use or other pending result) stalls the stage. It sits between fetch and execute and replaces stall-driven instruction holding with lossless back-pressure.

---
 rtl/id_operand_stage.sv | 147 ++++++++++++++
 tb/tb_id_operand_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// id_operand_stage: decode/operand-fetch stage between fetch and execute.
// Holds one entry in a main register and one in a skid register so that
// upstream sees lossless back-pressure with in_ready depending only on
// registered state. Source operands are resolved against priority-ordered
// forwarding sources (index 0 = youngest, highest priority); a match on a
// pending result stalls the entry in the main register.
//
// Optional feature macro: ID_X0_GUARD_EN -- when defined, register index 0
// never matches a forwarding source, so it always reads the register file.
module id_operand_stage #(
  parameter int WORD_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int INSTR_W   = 32,
  parameter int REG_IDX_W = 5,
  parameter int NUM_SRC   = 2,
  parameter int NUM_FWD   = 3
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [ADDR_W-1:0]             in_pc,
  input  logic [INSTR_W-1:0]            in_instr,
  input  logic [NUM_SRC-1:0]            in_src_use,
  input  logic [NUM_SRC*REG_IDX_W-1:0]  in_src_reg,
  output logic [NUM_SRC*REG_IDX_W-1:0]  rf_rd_reg,
  input  logic [NUM_SRC*WORD_W-1:0]     rf_rd_data,
  input  logic [NUM_FWD-1:0]            fwd_valid,
  input  logic [NUM_FWD-1:0]            fwd_pending,
  input  logic [NUM_FWD*REG_IDX_W-1:0]  fwd_reg,
  input  logic [NUM_FWD*WORD_W-1:0]     fwd_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_W-1:0]             out_pc,
  output logic [INSTR_W-1:0]            out_instr,
  output logic [NUM_SRC*WORD_W-1:0]     out_data,
  output logic                          out_hazard
);

`ifdef ID_X0_GUARD_EN
  localparam bit X0_GUARD = 1'b1;
`else
  localparam bit X0_GUARD = 1'b0;
`endif

  typedef struct packed {
    logic                         valid;
    logic [ADDR_W-1:0]            pc;
    logic [INSTR_W-1:0]           instr;
    logic [NUM_SRC-1:0]           src_use;
    logic [NUM_SRC*REG_IDX_W-1:0] src_reg;
  } entry_t;

  entry_t m_r;
  entry_t s_r;
  entry_t m_next_s;
  entry_t s_next_s;
  entry_t in_entry_s;

  logic                      xfer_s;
  logic                      advance_s;
  logic                      any_hazard_s;
  logic [NUM_SRC-1:0]        op_hazard_s;
  logic [NUM_SRC*WORD_W-1:0] op_data_s;
  logic [NUM_FWD-1:0]        match_s [NUM_SRC];
  logic [WORD_W-1:0]         sel_data_s;
  logic                      sel_pend_s;

  assign in_entry_s = {1'b1, in_pc, in_instr, in_src_use, in_src_reg};

  // Handshake: accept only while the skid slot is free (registered state only).
  assign in_ready     = ~s_r.valid;
  assign xfer_s       = in_valid & ~s_r.valid;
  assign any_hazard_s = |op_hazard_s;
  assign advance_s    = m_r.valid & ~any_hazard_s & out_ready;

  // Forwarding match matrix: operand i against forwarding source k.
  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    for (genvar gk = 0; gk < NUM_FWD; gk++) begin : g_fwd
      assign match_s[gi][gk] =
        m_r.src_use[gi] & fwd_valid[gk] &
        (fwd_reg[gk*REG_IDX_W +: REG_IDX_W] == m_r.src_reg[gi*REG_IDX_W +: REG_IDX_W]) &
        ~(X0_GUARD & (m_r.src_reg[gi*REG_IDX_W +: REG_IDX_W] == {REG_IDX_W{1'b0}}));
    end
  end

  // Next-state of main/skid registers: refill M from S first so order is kept.
  always_comb begin
    m_next_s = m_r;
    s_next_s = s_r;
    if (!m_r.valid || advance_s) begin
      if (s_r.valid) begin
        m_next_s = s_r;
        s_next_s = '0;
      end else if (xfer_s) begin
        m_next_s = in_entry_s;
        s_next_s = s_r;
      end else begin
        m_next_s = '0;
        s_next_s = s_r;
      end
    end else begin
      if (xfer_s) begin
        s_next_s = in_entry_s;
      end else begin
        s_next_s = s_r;
      end
    end
  end

  // State register; clr discards both in-flight entries.
  always_ff @(posedge clk) begin
    if (clr) begin
      m_r <= '0;
      s_r <= '0;
    end else begin
      m_r <= m_next_s;
      s_r <= s_next_s;
    end
  end

  // Operand resolution: lowest-index matching source wins (scan high to low).
  always_comb begin
    op_hazard_s = '0;
    op_data_s   = '0;
    sel_data_s  = '0;
    sel_pend_s  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      sel_data_s = rf_rd_data[i*WORD_W +: WORD_W];
      sel_pend_s = 1'b0;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        sel_data_s = match_s[i][k] ? fwd_data[k*WORD_W +: WORD_W] : sel_data_s;
        sel_pend_s = match_s[i][k] ? fwd_pending[k] : sel_pend_s;
      end
      op_hazard_s[i]               = m_r.src_use[i] & sel_pend_s;
      op_data_s[i*WORD_W +: WORD_W] = m_r.src_use[i] ? sel_data_s : {WORD_W{1'b0}};
    end
  end

  assign out_hazard = m_r.valid & any_hazard_s;
  assign out_valid  = m_r.valid & ~any_hazard_s;
  assign out_pc     = m_r.valid ? m_r.pc      : {ADDR_W{1'b0}};
  assign out_instr  = m_r.valid ? m_r.instr   : {INSTR_W{1'b0}};
  assign rf_rd_reg  = m_r.valid ? m_r.src_reg : {(NUM_SRC*REG_IDX_W){1'b0}};
  assign out_data   = m_r.valid ? op_data_s   : {(NUM_SRC*WORD_W){1'b0}};

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed scenarios followed by
// randomized traffic, checked against a queue-based reference model.
module tb_id_operand_stage;
  localparam int W  = 32;
  localparam int A  = 32;
  localparam int I  = 32;
  localparam int R  = 5;
  localparam int NS = 2;
  localparam int NF = 3;
`ifdef ID_X0_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr;
  logic             in_valid;
  logic             in_ready;
  logic [A-1:0]     in_pc;
  logic [I-1:0]     in_instr;
  logic [NS-1:0]    in_src_use;
  logic [NS*R-1:0]  in_src_reg;
  logic [NS*R-1:0]  rf_rd_reg;
  logic [NS*W-1:0]  rf_rd_data;
  logic [NF-1:0]    fwd_valid;
  logic [NF-1:0]    fwd_pending;
  logic [NF*R-1:0]  fwd_reg;
  logic [NF*W-1:0]  fwd_data;
  logic             out_valid;
  logic             out_ready;
  logic [A-1:0]     out_pc;
  logic [I-1:0]     out_instr;
  logic [NS*W-1:0]  out_data;
  logic             out_hazard;

  logic [W-1:0] rf [32];
  assign rf_rd_data = {rf[rf_rd_reg[2*R-1:R]], rf[rf_rd_reg[R-1:0]]};

  id_operand_stage dut (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_instr(in_instr), .in_src_use(in_src_use), .in_src_reg(in_src_reg),
    .rf_rd_reg(rf_rd_reg), .rf_rd_data(rf_rd_data),
    .fwd_valid(fwd_valid), .fwd_pending(fwd_pending), .fwd_reg(fwd_reg), .fwd_data(fwd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .out_data(out_data), .out_hazard(out_hazard)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [A-1:0]    pc;
    logic [I-1:0]    instr;
    logic [NS-1:0]   su;
    logic [NS*R-1:0] sr;
  } ent_t;

  ent_t q[$];
  int   nvec = 0;
  int   nerr = 0;
  bit   known = 1'b0;
  bit   last_xfer = 1'b0;
  bit   accepted;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference operand resolution straight from the forwarding rules.
  function automatic void model_ops(input ent_t e, output logic [NS*W-1:0] d, output bit hz);
    d  = '0;
    hz = 1'b0;
    for (int i = 0; i < NS; i++) begin
      int hitk;
      logic [R-1:0] r;
      hitk = -1;
      r = e.sr[i*R +: R];
      if (e.su[i]) begin
        for (int k = 0; k < NF; k++)
          if (hitk < 0 && fwd_valid[k] && fwd_reg[k*R +: R] == r && !(GUARD && r == 5'd0))
            hitk = k;
        if (hitk < 0) d[i*W +: W] = rf[r];
        else if (fwd_pending[hitk]) hz = 1'b1;
        else d[i*W +: W] = fwd_data[hitk*W +: W];
      end
    end
  endfunction

  // One clock: check outputs against model, then advance the model.
  task automatic step();
    ent_t cur;
    logic [NS*W-1:0] ed;
    bit hz, er, ev, adv;
    #1;
    er = (q.size() < 2);
    ev = 1'b0; hz = 1'b0; ed = '0;
    if (q.size() > 0) begin
      model_ops(q[0], ed, hz);
      ev = !hz;
    end
    if (known) begin
      chk("in_ready", in_ready, er);
      chk("out_valid", out_valid, ev);
      chk("out_hazard", out_hazard, (q.size() > 0) && hz);
      if (q.size() > 0) begin
        chk("out_pc", out_pc, q[0].pc);
        chk("out_instr", out_instr, q[0].instr);
        chk("rf_rd_reg", rf_rd_reg, q[0].sr);
      end else begin
        chk("out_pc_idle", out_pc, 32'h0);
        chk("out_instr_idle", out_instr, 32'h0);
        chk("rf_rd_reg_idle", rf_rd_reg, 10'h0);
      end
      if (!hz) chk("out_data", out_data, ed);
    end
    cur = '{in_pc, in_instr, in_src_use, in_src_reg};
    adv = ev && out_ready;
    last_xfer = in_valid && er && !clr;
    @(posedge clk);
    if (clr) begin
      q.delete();
      known = 1'b1;
    end else begin
      if (adv) q.delete(0);
      if (last_xfer) q.push_back(cur);
    end
    @(negedge clk);
  endtask

  initial begin
    clr = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_src_use = '0; in_src_reg = '0;
    fwd_valid = '0; fwd_pending = '0; fwd_reg = '0; fwd_data = '0; out_ready = 1'b0;
    for (int j = 0; j < 32; j++) rf[j] = $urandom;
    @(negedge clk);

    // Reset state
    clr = 1'b1; step(); clr = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_hazard", out_hazard, 1'b0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_out_data", out_data, 64'h0);
    step();

    // Streaming 0x0, 0x4, 0x8 with out_ready=1
    out_ready = 1'b1; in_valid = 1'b1;
    for (int j = 0; j < 3; j++) begin
      in_pc = 32'(j * 4); in_instr = $urandom; in_src_use = 2'($urandom); in_src_reg = 10'($urandom);
      if (j > 0) begin
        #1;
        chk("stream_valid", out_valid, 1'b1);
        chk("stream_pc", out_pc, 32'((j - 1) * 4));
        chk("stream_ready", in_ready, 1'b1);
      end
      step();
    end
    in_valid = 1'b0;
    #1; chk("stream_pc_last", out_pc, 32'h8);
    step();

    // Back-pressure: fill M and S, hold third upstream
    out_ready = 1'b0; in_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin
      in_pc = 32'h10 + 32'(j * 4); in_instr = $urandom; in_src_use = 2'b00;
      step();
    end
    in_pc = 32'h18; in_instr = $urandom;
    #1; chk("bp_in_ready", in_ready, 1'b0);
    step(); step();
    out_ready = 1'b1;
    accepted = 1'b0;
    for (int t = 0; t < 6 && !accepted; t++) begin
      step();
      accepted = last_xfer;
    end
    chk("bp_accept_timeout", accepted, 1'b1);
    in_valid = 1'b0;
    repeat (4) step();

    // Forwarding priority
    clr = 1'b1; step(); clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_pc = 32'h100; in_src_use = 2'b11;
    in_src_reg = {5'd6, 5'd5};
    step();
    in_valid = 1'b0;
    fwd_valid = 3'b111; fwd_pending = 3'b000;
    fwd_reg = {5'd6, 5'd5, 5'd5};
    fwd_data = {32'hCCCC, 32'hBBBB, 32'hAAAA};
    #1; chk("fwd_prio", out_data, {32'hCCCC, 32'hAAAA});
    step();

    // Pending forward on source 0 stalls for two cycles
    fwd_valid = 3'b001; fwd_pending = 3'b001; out_ready = 1'b1;
    for (int t = 0; t < 2; t++) begin
      #1;
      chk("pend_hazard", out_hazard, 1'b1);
      chk("pend_valid", out_valid, 1'b0);
      step();
    end
    fwd_pending = 3'b000;
    #1;
    chk("pend_release_valid", out_valid, 1'b1);
    chk("pend_release_data", out_data[W-1:0], 32'hAAAA);
    step();

    // Register 0 forwarding
    clr = 1'b1; step(); clr = 1'b0;
    out_ready = 1'b0; in_valid = 1'b1; in_src_use = 2'b01; in_src_reg = 10'h0;
    step();
    in_valid = 1'b0; rf[0] = 32'h0;
    fwd_valid = 3'b001; fwd_reg = '0; fwd_data = {64'h0, 32'h1234};
    #1; chk("x0_data", out_data[W-1:0], GUARD ? 32'h0 : 32'h1234);
    step();

    // clr with both registers full and in_valid high
    fwd_valid = '0; in_valid = 1'b1;
    for (int j = 0; j < 2; j++) begin in_pc = 32'h200 + 32'(j * 4); step(); end
    clr = 1'b1; step(); clr = 1'b0; in_valid = 1'b0;
    #1;
    chk("clr_out_valid", out_valid, 1'b0);
    chk("clr_in_ready", in_ready, 1'b1);
    chk("clr_out_pc", out_pc, 32'h0);
    step();

    // Randomized traffic
    repeat (400) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      in_pc       = $urandom;
      in_instr    = $urandom;
      in_src_use  = 2'($urandom);
      in_src_reg  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      out_ready   = ($urandom_range(0, 3) != 0);
      fwd_valid   = 3'($urandom);
      fwd_pending = 3'($urandom) & 3'($urandom);
      for (int k = 0; k < NF; k++) begin
        fwd_reg[k*R +: R]  = 5'($urandom_range(0, 7));
        fwd_data[k*W +: W] = $urandom;
      end
      rf[$urandom_range(0, 31)] = $urandom;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
